// File: rtl/gpu_msg_pkg.sv
// Shared scheduler/core message definitions: frame width, frame types, mask reset value.
package gpu_msg_pkg;

  localparam int FRAME_W = 16;
  localparam logic [15:0] AC_MASK_RESET = 16'hFFFF;

  typedef enum logic [2:0] {
    FT_NONE,
    FT_INS,
    FT_MASK_R0,
    FT_MASK_AC,
    FT_R0
  } frame_type_e;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module frame_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          pop_ok, push_ok;

  // A pop on an empty FIFO is ignored; a push on a full FIFO needs a real pop alongside.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/core_frame_receiver.sv
// Per-core deserialiser for the scheduler broadcast: buffers instruction frames and
// applies mask / R0 frames to core-local state.
module core_frame_receiver
  import gpu_msg_pkg::*;
#(
  parameter int FRAME_W    = gpu_msg_pkg::FRAME_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CORE_ID_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CORE_ID_W-1:0] core_id,
  input  logic                 val_ins,
  input  logic                 val_mask_R0,
  input  logic                 val_mask_ac,
  input  logic                 val_R0,
  input  logic                 instruction,
  input  logic                 ins_pop,
  input  logic                 exec_idle,
  output logic [FRAME_W-1:0]   ins_data,
  output logic                 ins_valid,
  output logic                 r0_wr,
  output logic [FRAME_W-1:0]   r0_data,
  output logic                 core_active,
  output logic                 rtr,
  output logic                 ready,
  output logic                 proto_err,
  output logic                 ovf
);

  localparam int CW = $clog2(FRAME_W);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  frame_type_e        type_q, type_d, bit_type;
  logic [FRAME_W-1:0] r0_mask_q, r0_mask_d;
  logic [FRAME_W-1:0] ac_mask_q, ac_mask_d;
  logic [FRAME_W-1:0] r0_data_q, r0_data_d;
  logic               r0_wr_q, r0_wr_d;
  logic               perr_q, perr_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         strb;
  logic               multi, push;
  logic [AW:0]        fifo_count;
  logic               fifo_full, fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      type_q    <= FT_NONE;
      r0_mask_q <= '0;
      ac_mask_q <= FRAME_W'(AC_MASK_RESET);
      r0_data_q <= '0;
      r0_wr_q   <= 1'b0;
      perr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      r0_mask_q <= r0_mask_d;
      ac_mask_q <= ac_mask_d;
      r0_data_q <= r0_data_d;
      r0_wr_q   <= r0_wr_d;
      perr_q    <= perr_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    strb      = {val_ins, val_mask_R0, val_mask_ac, val_R0};
    bit_type  = FT_NONE;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    r0_mask_d = r0_mask_q;
    ac_mask_d = ac_mask_q;
    r0_data_d = r0_data_q;
    r0_wr_d   = 1'b0;
    perr_d    = perr_q;
    ovf_d     = ovf_q;
    push      = 1'b0;

    case (strb)
      4'b1000: bit_type = FT_INS;
      4'b0100: bit_type = FT_MASK_R0;
      4'b0010: bit_type = FT_MASK_AC;
      4'b0001: bit_type = FT_R0;
      default: bit_type = FT_NONE;
    endcase
    multi = (strb != 4'b0000) && (bit_type == FT_NONE);

    if (multi) begin
      perr_d = 1'b1;
      cnt_d  = '0;
      type_d = FT_NONE;
    end else if (bit_type != FT_NONE) begin
      if (cnt_q != '0 && bit_type != type_q) begin
        // Type switch mid-frame: drop the partial frame, this bit starts a new one.
        perr_d  = 1'b1;
        shift_d = {{(FRAME_W-1){1'b0}}, instruction};
        cnt_d   = CW'(1);
        type_d  = bit_type;
      end else begin
        shift_d = {shift_q[FRAME_W-2:0], instruction};
        type_d  = bit_type;
        if (cnt_q == CW'(FRAME_W-1)) begin
          cnt_d  = '0;
          type_d = FT_NONE;
          case (bit_type)
            FT_INS:     push = 1'b1;
            FT_MASK_R0: r0_mask_d = shift_d;
            FT_MASK_AC: ac_mask_d = shift_d;
            FT_R0: begin
              if (r0_mask_q[core_id]) begin
                r0_data_d = shift_d;
                r0_wr_d   = 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (push && fifo_full && !ins_pop) ovf_d = 1'b1;
  end

  frame_fifo #(
    .W     (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (ins_pop),
    .din   (shift_d),
    .dout  (ins_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ins_valid   = !fifo_empty;
  assign r0_wr       = r0_wr_q;
  assign r0_data     = r0_data_q;
  assign core_active = ac_mask_q[core_id];
  assign rtr         = (fifo_count < (AW+1)'(FIFO_DEPTH));
  assign ready       = fifo_empty && (cnt_q == '0) && exec_idle;
  assign proto_err   = perr_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_core_frame_receiver.sv
// Directed bench for core_frame_receiver: frame types, FIFO limits, protocol errors, reset.
module tb_core_frame_receiver;

  localparam logic [3:0] K_INS = 4'b1000;
  localparam logic [3:0] K_MR0 = 4'b0100;
  localparam logic [3:0] K_MAC = 4'b0010;
  localparam logic [3:0] K_R0  = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  core_id = 4'd5;
  logic [3:0]  strb = 4'b0000;
  logic        instruction = 1'b0;
  logic        ins_pop = 1'b0;
  logic        exec_idle = 1'b1;
  logic [15:0] ins_data;
  logic        ins_valid;
  logic        r0_wr;
  logic [15:0] r0_data;
  logic        core_active;
  logic        rtr;
  logic        ready;
  logic        proto_err;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_frame_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .core_id     (core_id),
    .val_ins     (strb[3]),
    .val_mask_R0 (strb[2]),
    .val_mask_ac (strb[1]),
    .val_R0      (strb[0]),
    .instruction (instruction),
    .ins_pop     (ins_pop),
    .exec_idle   (exec_idle),
    .ins_data    (ins_data),
    .ins_valid   (ins_valid),
    .r0_wr       (r0_wr),
    .r0_data     (r0_data),
    .core_active (core_active),
    .rtr         (rtr),
    .ready       (ready),
    .proto_err   (proto_err),
    .ovf         (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive bits hi..lo of data (MSB first), one per cycle, on the negedge.
  task automatic send_bits(input logic [3:0] kind, input logic [15:0] data,
                           input int hi, input int lo, input bit pop_last);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      strb        = kind;
      instruction = data[i];
      ins_pop     = pop_last && (i == lo);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      strb    = 4'b0000;
      ins_pop = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [3:0] kind, input logic [15:0] data, input bit pop_last);
    send_bits(kind, data, 15, 0, pop_last);
    idle(1);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, 32'(ins_valid), 32'd1);
    check({tag, "_data"}, 32'(ins_data), 32'(exp));
    ins_pop = 1'b1;
    @(negedge clk);
    ins_pop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    strb    = 4'b0000;
    ins_pop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_rtr", 32'(rtr), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_core_active", 32'(core_active), 32'd1);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_r0_wr", 32'(r0_wr), 32'd0);
    check("rst_r0_data", 32'(r0_data), 32'd0);

    // Basic instruction frame
    send_frame(K_INS, 16'hA5C3, 1'b0);
    check("ins_rtr", 32'(rtr), 32'd1);
    check("ins_ready", 32'(ready), 32'd0);
    pop_check("ins_a5c3", 16'hA5C3);
    check("ins_drained", 32'(ins_valid), 32'd0);
    check("ins_ready_after", 32'(ready), 32'd1);

    // R0 writes gated by r0_mask[core_id]
    send_frame(K_MR0, 16'h0020, 1'b0);
    check("r0_no_pulse_on_mask", 32'(r0_wr), 32'd0);
    send_frame(K_R0, 16'h1234, 1'b0);
    check("r0_wr_pulse", 32'(r0_wr), 32'd1);
    check("r0_data", 32'(r0_data), 32'h1234);
    idle(1);
    check("r0_wr_one_cycle", 32'(r0_wr), 32'd0);
    send_frame(K_MR0, 16'h0001, 1'b0);
    send_frame(K_R0, 16'h5678, 1'b0);
    check("r0_masked_no_wr", 32'(r0_wr), 32'd0);
    check("r0_masked_data_hold", 32'(r0_data), 32'h1234);

    // Active-core mask
    send_frame(K_MAC, 16'hFFDF, 1'b0);
    check("ac_off", 32'(core_active), 32'd0);
    send_frame(K_MAC, 16'hFFFF, 1'b0);
    check("ac_on", 32'(core_active), 32'd1);

    // FIFO fill, full-with-pop acceptance, then overflow
    send_frame(K_INS, 16'h1111, 1'b0);
    send_frame(K_INS, 16'h2222, 1'b0);
    send_frame(K_INS, 16'h3333, 1'b0);
    check("fill3_rtr", 32'(rtr), 32'd1);
    send_frame(K_INS, 16'h4444, 1'b0);
    check("fill4_rtr", 32'(rtr), 32'd0);
    send_frame(K_INS, 16'h5555, 1'b1);
    check("full_pop_ovf", 32'(ovf), 32'd0);
    check("full_pop_head", 32'(ins_data), 32'h2222);
    check("full_pop_rtr", 32'(rtr), 32'd0);
    send_frame(K_INS, 16'h6666, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    pop_check("drain0", 16'h2222);
    pop_check("drain1", 16'h3333);
    pop_check("drain2", 16'h4444);
    pop_check("drain3", 16'h5555);
    check("drain_empty", 32'(ins_valid), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);
    ins_pop = 1'b1;
    @(negedge clk);
    ins_pop = 1'b0;
    check("pop_empty_ignored", 32'(ins_valid), 32'd0);
    check("pop_empty_rtr", 32'(rtr), 32'd1);

    do_reset();
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Stretched frame
    send_bits(K_INS, 16'hBEEF, 15, 8, 1'b0);
    idle(3);
    check("stretch_mid_ready", 32'(ready), 32'd0);
    check("stretch_mid_valid", 32'(ins_valid), 32'd0);
    send_bits(K_INS, 16'hBEEF, 7, 0, 1'b0);
    idle(1);
    check("stretch_perr", 32'(proto_err), 32'd0);
    pop_check("stretch", 16'hBEEF);

    // Type change mid-frame
    send_bits(K_INS, 16'hFFFF, 15, 8, 1'b0);
    send_bits(K_R0, 16'hFFFF, 0, 0, 1'b0);
    idle(1);
    check("type_change_perr", 32'(proto_err), 32'd1);
    check("type_change_no_push", 32'(ins_valid), 32'd0);
    check("type_change_busy", 32'(ready), 32'd0);

    do_reset();
    check("perr_cleared", 32'(proto_err), 32'd0);

    // Two strobes at once
    send_bits(K_INS | K_MAC, 16'hFFFF, 0, 0, 1'b0);
    idle(1);
    check("multi_perr", 32'(proto_err), 32'd1);
    check("multi_cnt_zero", 32'(ready), 32'd1);

    // Mid-frame reset from a non-reset state
    send_frame(K_MAC, 16'hFFDF, 1'b0);
    send_frame(K_INS, 16'h7777, 1'b0);
    send_bits(K_INS, 16'h0F0F, 15, 6, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    strb      = 4'b0000;
    exec_idle = 1'b0;
    @(negedge clk);
    check("mrst_ins_valid", 32'(ins_valid), 32'd0);
    check("mrst_rtr", 32'(rtr), 32'd1);
    check("mrst_ready_follows_idle", 32'(ready), 32'd0);
    check("mrst_core_active", 32'(core_active), 32'd1);
    check("mrst_proto_err", 32'(proto_err), 32'd0);
    check("mrst_r0_data", 32'(r0_data), 32'd0);
    exec_idle = 1'b1;
    @(negedge clk);
    check("mrst_ready_idle", 32'(ready), 32'd1);
    reset = 1'b0;
    send_frame(K_INS, 16'hC0DE, 1'b0);
    check("post_rst_perr", 32'(proto_err), 32'd0);
    pop_check("post_rst", 16'hC0DE);

    // R0 frame after reset: r0_mask is 0 again, so no write
    send_frame(K_R0, 16'h9999, 1'b0);
    check("post_rst_r0_masked", 32'(r0_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
